// File: rtl/io_cfg_pkg.sv
// Shared types and constants for the IO bank configuration sequencer.
// Defines the sequencer state enum and the per-tile config bit layout.
package io_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StDone
  } cfg_state_e;

  localparam int unsigned BITS_PER_TILE_DFLT = 4;

  // Meaning of each wl row within one IO tile.
  localparam int unsigned FF0_CFG    = 0;
  localparam int unsigned FF1_CFG    = 1;
  localparam int unsigned A2F_SEL    = 2;
  localparam int unsigned OUTPAD_SEL = 3;

  function automatic int unsigned cyc_per_row(input int unsigned setup_cyc,
                                              input int unsigned pulse_cyc);
    return setup_cyc + pulse_cyc + 1;
  endfunction

endpackage

// File: rtl/io_cfg_phase_timer.sv
// Loadable down-counter; tc_o marks the last cycle of a loaded phase.
// A load of D gives D cycles with tc_o high on the final one.
module io_cfg_phase_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/io_bank_cfg_ctrl.sv
// Bank configuration sequencer: shadows per-tile words, then walks wl rows with
// setup/pulse/hold phases. IO_BANK_CFG_READBACK_EN adds the rb_tile/rb_data readback port.
module io_bank_cfg_ctrl
  import io_cfg_pkg::*;
#(
  parameter int unsigned NUM_TILES     = 8,
  parameter int unsigned BITS_PER_TILE = BITS_PER_TILE_DFLT,
  parameter int unsigned SETUP_CYC     = 1,
  parameter int unsigned PULSE_CYC     = 2,
  parameter int unsigned TILE_AW       = $clog2(NUM_TILES)
) (
  input  logic                     prog_clk,
  input  logic                     pReset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [TILE_AW-1:0]       cfg_tile,
  input  logic [BITS_PER_TILE-1:0] cfg_data,
  input  logic                     cfg_start,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err,
`ifdef IO_BANK_CFG_READBACK_EN
  input  logic [TILE_AW-1:0]       rb_tile,
  output logic [BITS_PER_TILE-1:0] rb_data,
`endif
  output logic [NUM_TILES-1:0]     bl,
  output logic [BITS_PER_TILE-1:0] wl
);

  localparam int unsigned IDX_W  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int unsigned ROW_W  = (BITS_PER_TILE > 1) ? $clog2(BITS_PER_TILE) : 1;
  localparam int unsigned PH_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BITS_PER_TILE - 1);
  // One extra bit so an all-ones cfg_tile can still compare against NUM_TILES.
  localparam logic [TILE_AW:0] TILE_LIM = (TILE_AW + 1)'(NUM_TILES);

  cfg_state_e state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [NUM_TILES-1:0][BITS_PER_TILE-1:0] shadow_q;
  logic err_q;

  logic             wr_en, tile_ok;
  logic [IDX_W-1:0] wr_idx;
  logic             tmr_load, tmr_tc;
  logic [PH_W-1:0]  tmr_val;

  assign tile_ok = ({1'b0, cfg_tile} < TILE_LIM);
  assign wr_idx  = cfg_tile[IDX_W-1:0];
  assign wr_en   = cfg_valid && cfg_ready;

  io_cfg_phase_timer #(
    .WIDTH(PH_W)
  ) u_phase_timer (
    .clk_i      (prog_clk),
    .rst_i      (pReset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  // State register, row counter, shadow and error flag.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      err_q   <= wr_en && !tile_ok;
      if (wr_en && tile_ok) begin
        shadow_q[wr_idx] <= cfg_data;
      end
    end
  end

  // Next-state and phase timer load.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d = StSetup;
          row_d   = '0;
        end
      end
      StSetup: if (tmr_tc) state_d = StPulse;
      StPulse: if (tmr_tc) state_d = StHold;
      StHold: begin
        if (row_q == LAST_ROW) begin
          state_d = StDone;
        end else begin
          state_d = StSetup;
          row_d   = row_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    tmr_load = (state_d != state_q) && ((state_d == StSetup) || (state_d == StPulse));
    tmr_val  = (state_d == StSetup) ? PH_W'(SETUP_CYC) : PH_W'(PULSE_CYC);
  end

  // Outputs decoded from registered state.
  always_comb begin
    cfg_ready = (state_q == StIdle);
    cfg_busy  = (state_q == StSetup) || (state_q == StPulse) || (state_q == StHold);
    cfg_done  = (state_q == StDone);
    cfg_err   = err_q;
    bl        = '0;
    wl        = '0;
    if (state_q != StIdle) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        bl[t] = shadow_q[t][row_q];
      end
    end
    if (state_q == StPulse) begin
      wl[row_q] = 1'b1;
    end
  end

`ifdef IO_BANK_CFG_READBACK_EN
  always_comb begin
    rb_data = '0;
    if ({1'b0, rb_tile} < TILE_LIM) begin
      rb_data = shadow_q[rb_tile[IDX_W-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_io_bank_cfg_ctrl.sv
// Self-checking bench for io_bank_cfg_ctrl: directed scenarios plus random stimulus,
// all checked every cycle against a cycle-count based reference model.
module tb_io_bank_cfg_ctrl;

  localparam int NT  = 8;
  localparam int BPT = 4;
  localparam int SC  = 1;
  localparam int PC  = 2;
  localparam int AW  = 4;
  localparam int CPR = SC + PC + 1;
  localparam int TOT = BPT * CPR;

  logic           prog_clk = 1'b0;
  logic           pReset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [AW-1:0]  cfg_tile;
  logic [BPT-1:0] cfg_data;
  logic           cfg_start;
  logic           cfg_busy;
  logic           cfg_done;
  logic           cfg_err;
  logic [NT-1:0]  bl;
  logic [BPT-1:0] wl;
`ifdef IO_BANK_CFG_READBACK_EN
  logic [AW-1:0]  rb_tile;
  logic [BPT-1:0] rb_data;
`endif

  io_bank_cfg_ctrl #(
    .NUM_TILES     (NT),
    .BITS_PER_TILE (BPT),
    .SETUP_CYC     (SC),
    .PULSE_CYC     (PC),
    .TILE_AW       (AW)
  ) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_tile  (cfg_tile),
    .cfg_data  (cfg_data),
    .cfg_start (cfg_start),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
`ifdef IO_BANK_CFG_READBACK_EN
    .rb_tile   (rb_tile),
    .rb_data   (rb_data),
`endif
    .bl        (bl),
    .wl        (wl)
  );

  always #5 prog_clk = ~prog_clk;

  int total = 0;
  int bad   = 0;

  // Model: shadow contents and k = cycles since the accepted start (0 = idle).
  logic [BPT-1:0] m_sh [NT];
  int             k;
  logic           m_err;
  int             done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int row, ph;
    logic [NT-1:0]  e_bl;
    logic [BPT-1:0] e_wl;
    e_bl = '0;
    e_wl = '0;
    if (k >= 1) begin
      row = (k - 1) / CPR;
      ph  = (k - 1) % CPR;
      if (row > BPT - 1) row = BPT - 1;
      for (int t = 0; t < NT; t++) e_bl[t] = m_sh[t][row];
      if (k <= TOT && ph >= SC && ph < SC + PC) e_wl = BPT'(1) << row;
    end
    check("ready", cfg_ready, k == 0);
    check("busy", cfg_busy, k >= 1 && k <= TOT);
    check("done", cfg_done, k == TOT + 1);
    check("err", cfg_err, m_err);
    check("bl", bl, e_bl);
    check("wl", wl, e_wl);
    check("wl_onehot", $countones(wl) <= 1, 1'b1);
`ifdef IO_BANK_CFG_READBACK_EN
    check("rb_data", rb_data, (rb_tile < NT) ? m_sh[rb_tile] : '0);
`endif
    if (cfg_done) done_seen++;
  endtask

  // One clock edge: advance the model with the inputs held across it, then compare.
  task automatic tick();
    logic rdy;
    @(posedge prog_clk);
    if (pReset) begin
      for (int i = 0; i < NT; i++) m_sh[i] = '0;
      k     = 0;
      m_err = 1'b0;
    end else begin
      rdy   = (k == 0);
      m_err = rdy && cfg_valid && (cfg_tile >= NT);
      if (rdy && cfg_valid && cfg_tile < NT) m_sh[cfg_tile] = cfg_data;
      if (k == 0) k = cfg_start ? 1 : 0;
      else if (k == TOT + 1) k = 0;
      else k++;
    end
    #1;
    compare_outputs();
  endtask

  task automatic write_tile(input int tile, input logic [BPT-1:0] data);
    cfg_valid = 1'b1;
    cfg_tile  = AW'(tile);
    cfg_data  = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  int lat;
  int hits;
  logic [NT-1:0] bl_or;

  initial begin
    pReset    = 1'b1;
    cfg_valid = 1'b0;
    cfg_tile  = '0;
    cfg_data  = '0;
    cfg_start = 1'b0;
`ifdef IO_BANK_CFG_READBACK_EN
    rb_tile   = '0;
`endif
    for (int i = 0; i < NT; i++) m_sh[i] = '0;
    k = 0; m_err = 1'b0; done_seen = 0;
    tick();
    tick();
    pReset = 1'b0;
    tick();
    check("rst_wl", wl, 0);
    check("rst_bl", bl, 0);
    check("rst_ready", cfg_ready, 1);

    // Two tiles, then a full bank program with latency measurement.
    write_tile(0, 4'b0101);
    write_tile(7, 4'b1010);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    lat = -1;
    for (int i = 2; i <= TOT + 2; i++) begin
      tick();
      if (i == SC + 1) begin
        check("r0_wl", wl, 4'b0001);
        check("r0_bl0", bl[0], 1);
        check("r0_bl7", bl[7], 0);
      end
      if (i == CPR + SC + 1) begin
        check("r1_wl", wl, 4'b0010);
        check("r1_bl0", bl[0], 0);
        check("r1_bl7", bl[7], 1);
      end
      if (cfg_done && lat < 0) lat = i;
    end
    check("done_lat", lat, TOT + 1);
    check("ready_again", cfg_ready, 1);

    // Write and start in the same cycle: the write must be programmed.
    cfg_valid = 1'b1; cfg_tile = 4'd3; cfg_data = 4'b1111; cfg_start = 1'b1;
    tick();
    cfg_valid = 1'b0; cfg_start = 1'b0;
    hits = 0;
    for (int i = 2; i <= TOT + 2; i++) begin
      tick();
      if (wl != 0 && bl[3]) hits++;
    end
    check("same_cyc_hits", hits, BPT * PC);

    // Out-of-range tile: error pulse, shadow untouched.
    write_tile(9, 4'b1111);
    check("oor_err", cfg_err, 1);
`ifdef IO_BANK_CFG_READBACK_EN
    rb_tile = 4'd9;
    #1;
    check("oor_rb", rb_data, 0);
    rb_tile = 4'd3;
`endif
    tick();
    check("oor_err_clr", cfg_err, 0);

    // Start/valid while busy must be ignored: exactly one done.
    done_seen = 0;
    cfg_start = 1'b1;
    tick();
    for (int i = 2; i <= TOT + 3; i++) begin
      cfg_start = 1'b1; cfg_valid = 1'b1; cfg_tile = 4'd1; cfg_data = 4'b1001;
      if (i > TOT) begin cfg_start = 1'b0; cfg_valid = 1'b0; end
      tick();
      if (i < TOT) check("busy_ready", cfg_ready, 0);
    end
    cfg_start = 1'b0; cfg_valid = 1'b0;
    check("one_done", done_seen, 1);

    // Reset during row 2 pulse: outputs clear, no done, next run programs zeros.
    done_seen = 0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 2; i <= 2 * CPR + SC + 1; i++) tick();
    check("pre_rst_wl", wl, 4'b0100);
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    check("mid_rst_wl", wl, 0);
    check("mid_rst_bl", bl, 0);
    check("mid_rst_ready", cfg_ready, 1);
    for (int i = 0; i < TOT + 2; i++) tick();
    check("mid_rst_nodone", done_seen, 0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    bl_or = '0;
    for (int i = 2; i <= TOT + 2; i++) begin
      tick();
      bl_or |= bl;
    end
    check("zero_prog_bl", bl_or, 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      pReset    = ($urandom_range(0, 149) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_tile  = AW'($urandom_range(0, 10));
      cfg_data  = BPT'($urandom);
      cfg_start = ($urandom_range(0, 11) == 0);
`ifdef IO_BANK_CFG_READBACK_EN
      rb_tile   = AW'($urandom_range(0, 15));
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
